upsampler_feed: RTL and testbench
=================================

UPSAMPLER_FEED -- requirements
Module: upsampler_feed

Interface
REQ-001 Parameter DW, default 16, sample width of each output component (matches the upsampler_input_x/y width).
REQ-002 Parameter AW, default 5, FIFO address width; depth = 2^AW = 32 entries of {x,y}.
REQ-003 sys_clk  in  1  single clock; every register is updated on the rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 enable  in  1  0 forces IDLE and flushes the FIFO; 1 allows operation.
REQ-006 underrun_zero  in  1  underrun output policy: 1 drives zero, 0 holds the last sample.
REQ-007 prime_level  in  AW+1  fill level required to leave PRIME; a value of 0 is treated as 1, and values above 2^AW are treated as 2^AW.
REQ-008 wr_valid  in  1  CPU-side sample pair offered.
REQ-009 wr_ready  out  1  sample pair accepted this cycle when wr_valid is also high.
REQ-010 wr_x, wr_y  in  DW each  signed sample pair being written.
REQ-011 ce_strobe  in  1  one-cycle sample-rate strobe (connected to ce_down).
REQ-012 out_x, out_y  out  DW each  signed, registered; drive upsampler_input_x/y.
REQ-013 out_valid  out  1  one-cycle pulse, high when out_x/out_y were loaded by a pop.
REQ-014 fill_level  out  AW+1  current FIFO occupancy, 0..2^AW.
REQ-015 state  out  2  current state: IDLE=0, PRIME=1, RUN=2; value 3 is never driven.
REQ-016 underrun_count  out  16  number of underruns, saturating.
REQ-017 underrun_clear  in  1  synchronous clear of underrun_count.

Function
REQ-018 The FIFO SHALL be first-word-fall-through with {x,y} stored together, and out_x/out_y SHALL only ever carry pairs written together.
REQ-019 wr_ready SHALL be (state!=IDLE) && (fill_level<2^AW), decoded from registered state; there is no write bypass when full, even on a pop cycle.
REQ-020 A write SHALL occur iff wr_valid&&wr_ready, and fill_level SHALL increment on the next edge.
REQ-021 IDLE: when enable=1, the block SHALL go to PRIME on the next edge; ce_strobe is ignored in IDLE.
REQ-022 PRIME: ce_strobe SHALL cause no pop and no underrun count.
REQ-023 PRIME: outputs SHALL hold their values.
REQ-024 PRIME: the block SHALL go to RUN on the first edge where the registered fill_level >= effective prime_level.
REQ-025 RUN, ce_strobe=1 with fill_level>0: the head pair SHALL be popped into out_x/out_y on that edge, out_valid SHALL be 1 for exactly the next cycle, and fill_level SHALL decrement (latency: 1 cycle from strobe to output).
REQ-026 Simultaneous write and pop SHALL both occur, leaving fill_level unchanged.
REQ-027 RUN, ce_strobe=1 with fill_level=0 (underrun): out_x/out_y SHALL be set to 0 if underrun_zero=1, otherwise held.
REQ-028 On underrun, out_valid SHALL stay 0.
REQ-029 On underrun, underrun_count SHALL increment, saturating at 0xFFFF.
REQ-030 On underrun, state SHALL go to PRIME.
REQ-031 A write arriving in the underrun cycle SHALL be accepted and counts toward re-priming.
REQ-032 underrun_clear SHALL zero underrun_count on the next edge and SHALL take priority over a same-cycle increment.
REQ-033 enable=0 in any non-IDLE state SHALL, on the next edge, set state to IDLE, reset the FIFO pointers (fill_level=0), zero out_x/out_y and out_valid, and discard any same-cycle write; underrun_count SHALL be retained.
REQ-034 FIFO pointers SHALL wrap modulo 2^AW; fill_level SHALL be derived from AW+1-bit pointers so that full (2^AW) and empty (0) are distinguished.
REQ-035 Sample data SHALL pass through unmodified, with no scaling or sign change.

Reset
REQ-036 rst=1 SHALL force on the next edge: state=IDLE, fill_level=0, out_x=out_y=0, out_valid=0, underrun_count=0, and pointers=0.
REQ-037 wr_ready SHALL be 0 while state=IDLE.
REQ-038 rst SHALL take priority over enable, writes, strobes and clear; rst asserted mid-RUN SHALL discard FIFO contents.

Verification
REQ-039 Prime and run: enable=1, prime_level=4, write (100,-100),(200,-200),(300,-300),(400,-400), then strobes every 8 cycles -> state goes PRIME->RUN after the 4th write; each strobe is followed 1 cycle later by out_valid=1 and the pairs appear in write order; fill_level decrements 4->0.
REQ-040 Underrun: in RUN with fill_level=0, strobe with underrun_zero=1 -> out_x=out_y=0, out_valid=0, underrun_count=1, state=PRIME; repeat with underrun_zero=0 -> outputs hold (400,-400).
REQ-041 Full/concurrency: write 32 pairs with no strobes -> fill_level=32 and wr_ready=0; a 33rd write is rejected; then, on a single cycle, strobe plus write (after one free slot exists) -> fill_level is unchanged.
REQ-042 Disable mid-run: fill_level=10 in RUN, drop enable -> next cycle state=IDLE, fill_level=0, out_x=out_y=0, wr_ready=0, underrun_count kept; re-enable -> PRIME.
REQ-043 Counter: force 65537 underruns -> underrun_count=0xFFFF; assert clear in the same cycle as an underrun -> underrun_count=0.
REQ-044 prime_level=0 with one write -> RUN is entered after that single write.

Source files
------------

// File: rtl/upsampler_feed.sv
// upsampler_feed: CPU-to-upsampler sample feeder.
// A first-word-fall-through FIFO of {x,y} pairs, written from the CPU side
// and drained one pair per ce_strobe once enough samples have been primed.
// An empty FIFO on a strobe is an underrun: the block counts it and
// re-primes before resuming.
module upsampler_feed #(
  parameter int DW = 16,
  parameter int AW = 5
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 underrun_zero,
  input  logic [AW:0]          prime_level,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic signed [DW-1:0] wr_x,
  input  logic signed [DW-1:0] wr_y,
  input  logic                 ce_strobe,
  output logic signed [DW-1:0] out_x,
  output logic signed [DW-1:0] out_y,
  output logic                 out_valid,
  output logic [AW:0]          fill_level,
  output logic [1:0]           state,
  output logic [15:0]          underrun_count,
  input  logic                 underrun_clear
);

  localparam int DEPTH = 1 << AW;

  // Occupancy constants expressed in the AW+1-bit pointer domain.
  localparam logic [AW:0] C_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] C_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] C_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t              r_state;
  logic [AW:0]         r_wr_ptr;
  logic [AW:0]         r_rd_ptr;
  logic [2*DW-1:0]     r_mem [DEPTH];
  logic signed [DW-1:0] r_out_x;
  logic signed [DW-1:0] r_out_y;
  logic                r_out_valid;
  logic [15:0]         r_underrun_count;

  logic [AW:0]     w_fill;
  logic            w_full;
  logic            w_empty;
  logic            w_wr_ready;
  logic            w_wr_en;
  logic            w_pop;
  logic            w_underrun;
  logic [AW:0]     w_prime_eff;
  logic [2*DW-1:0] w_head;

  // The extra pointer bit separates full (2^AW) from empty (0).
  assign w_fill     = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_fill == C_FULL);
  assign w_empty    = (w_fill == C_ZERO);
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

  // Ready only from registered state; a pop in the same cycle does not free a slot.
  assign w_wr_ready = (r_state != S_IDLE) && !w_full;

  // A write offered while disabling or resetting is dropped.
  assign w_wr_en    = wr_valid && w_wr_ready && enable && !rst;

  assign w_pop      = enable && (r_state == S_RUN) && ce_strobe && !w_empty;
  assign w_underrun = enable && (r_state == S_RUN) && ce_strobe && w_empty;

  // Clamp the priming threshold into 1..2^AW.
  always_comb begin
    w_prime_eff = prime_level;
    if (prime_level == C_ZERO) begin
      w_prime_eff = C_ONE;
    end else if (prime_level > C_FULL) begin
      w_prime_eff = C_FULL;
    end else begin
      w_prime_eff = prime_level;
    end
  end

  // FIFO storage: x and y are kept in one word so they can never be split.
  always_ff @(posedge sys_clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {wr_x, wr_y};
    end
  end

  // State machine, FIFO pointers and registered sample outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= C_ZERO;
      r_rd_ptr    <= C_ZERO;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_valid <= 1'b0;
    end else if (!enable) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= C_ZERO;
      r_rd_ptr    <= C_ZERO;
      r_out_x     <= '0;
      r_out_y     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;

      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + C_ONE;
      end

      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + C_ONE;
        r_out_x     <= w_head[2*DW-1:DW];
        r_out_y     <= w_head[DW-1:0];
        r_out_valid <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_state <= S_PRIME;
        end
        S_PRIME: begin
          // Strobes are ignored here; outputs keep their last values.
          if (w_fill >= w_prime_eff) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_underrun) begin
            r_state <= S_PRIME;
            if (underrun_zero) begin
              r_out_x <= '0;
              r_out_y <= '0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Saturating underrun counter; a clear wins over a same-cycle underrun.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_underrun_count <= 16'h0000;
    end else if (underrun_clear) begin
      r_underrun_count <= 16'h0000;
    end else if (w_underrun && (r_underrun_count != C_CNT_MAX)) begin
      r_underrun_count <= r_underrun_count + 16'h0001;
    end
  end

  assign wr_ready       = w_wr_ready;
  assign out_x          = r_out_x;
  assign out_y          = r_out_y;
  assign out_valid      = r_out_valid;
  assign fill_level     = w_fill;
  assign state          = r_state;
  assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_upsampler_feed.sv
// Self-checking bench for upsampler_feed: scenario tasks with a data scoreboard.
module tb_upsampler_feed;

  logic               sys_clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               underrun_zero;
  logic [5:0]         prime_level;
  logic               wr_valid;
  logic               wr_ready;
  logic signed [15:0] wr_x;
  logic signed [15:0] wr_y;
  logic               ce_strobe;
  logic signed [15:0] out_x;
  logic signed [15:0] out_y;
  logic               out_valid;
  logic [5:0]         fill_level;
  logic [1:0]         state;
  logic [15:0]        underrun_count;
  logic               underrun_clear;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  always #5 sys_clk = ~sys_clk;

  upsampler_feed #(.DW(16), .AW(5)) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .underrun_zero(underrun_zero),
    .prime_level(prime_level), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .ce_strobe(ce_strobe), .out_x(out_x), .out_y(out_y),
    .out_valid(out_valid), .fill_level(fill_level), .state(state),
    .underrun_count(underrun_count), .underrun_clear(underrun_clear)
  );

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Offer one pair; expected acceptance comes from the scenario, not the DUT.
  task automatic write_pair(input logic signed [15:0] x, input logic signed [15:0] y, input logic exp_acc);
    wr_valid = 1'b1; wr_x = x; wr_y = y;
    checks++; if (wr_ready !== exp_acc) begin errors++; $display("FAIL wr_ready got %b want %b", wr_ready, exp_acc); end
    if (exp_acc) sb.push_back({x, y});
    step();
    wr_valid = 1'b0;
  endtask

  // One strobe in RUN: next cycle must carry the scoreboard head for exactly one cycle.
  task automatic strobe_pop(input logic [5:0] exp_fill);
    logic [31:0] e;
    ce_strobe = 1'b1;
    step();
    ce_strobe = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pop_valid got %b want 1", out_valid); end
    checks++;
    if (sb.size() == 0) begin
      errors++; $display("FAIL pop_sb got empty scoreboard want a pending pair");
    end else begin
      e = sb.pop_front();
      if ({out_x, out_y} !== e) begin errors++; $display("FAIL pop_data got (%0d,%0d) want (%0d,%0d)", out_x, out_y, $signed(e[31:16]), $signed(e[15:0])); end
    end
    checks++; if (fill_level !== exp_fill) begin errors++; $display("FAIL pop_fill got %0d want %0d", fill_level, exp_fill); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pop_pulse got %b want 0", out_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; underrun_zero = 1'b1; prime_level = 6'd4;
    wr_valid = 1'b1; wr_x = 16'sd5; wr_y = 16'sd6; ce_strobe = 1'b1; underrun_clear = 1'b0;
    step(); step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (fill_level !== 6'd0) begin errors++; $display("FAIL rst_fill got %0d want 0", fill_level); end
    checks++; if (out_x !== 16'sd0 || out_y !== 16'sd0) begin errors++; $display("FAIL rst_out got (%0d,%0d) want (0,0)", out_x, out_y); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d want 0", underrun_count); end
    rst = 1'b0; enable = 1'b0; wr_valid = 1'b0;
    step();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_state got %0d want 0", state); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL idle_ready got %b want 0", wr_ready); end
    ce_strobe = 1'b0;
  endtask

  task automatic test_prime_run();
    enable = 1'b1; prime_level = 6'd4; underrun_zero = 1'b1;
    step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL prime_enter got %0d want 1", state); end
    write_pair(16'sd100, -16'sd100, 1'b1);
    write_pair(16'sd200, -16'sd200, 1'b1);
    ce_strobe = 1'b1; step(); ce_strobe = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL prime_strobe_valid got %b want 0", out_valid); end
    checks++; if (fill_level !== 6'd2) begin errors++; $display("FAIL prime_strobe_fill got %0d want 2", fill_level); end
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL prime_strobe_count got %0d want 0", underrun_count); end
    checks++; if (out_x !== 16'sd0) begin errors++; $display("FAIL prime_hold got %0d want 0", out_x); end
    write_pair(16'sd300, -16'sd300, 1'b1);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL prime_3rd got %0d want 1", state); end
    write_pair(16'sd400, -16'sd400, 1'b1);
    checks++; if (fill_level !== 6'd4) begin errors++; $display("FAIL prime_fill4 got %0d want 4", fill_level); end
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL run_enter got %0d want 2", state); end
    for (int i = 0; i < 4; i++) begin
      repeat (6) step();
      strobe_pop(6'(3 - i));
    end
  endtask

  task automatic test_underrun();
    underrun_zero = 1'b1;
    ce_strobe = 1'b1; step(); ce_strobe = 1'b0;
    checks++; if (out_x !== 16'sd0 || out_y !== 16'sd0) begin errors++; $display("FAIL ur_zero got (%0d,%0d) want (0,0)", out_x, out_y); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ur_valid got %b want 0", out_valid); end
    checks++; if (underrun_count !== 16'd1) begin errors++; $display("FAIL ur_count1 got %0d want 1", underrun_count); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL ur_state got %0d want 1", state); end
    prime_level = 6'd1;
    write_pair(16'sd400, -16'sd400, 1'b1);
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL reprime got %0d want 2", state); end
    strobe_pop(6'd0);
    underrun_zero = 1'b0;
    ce_strobe = 1'b1; step(); ce_strobe = 1'b0;
    checks++; if (out_x !== 16'sd400 || out_y !== -16'sd400) begin errors++; $display("FAIL ur_hold got (%0d,%0d) want (400,-400)", out_x, out_y); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ur_hold_valid got %b want 0", out_valid); end
    checks++; if (underrun_count !== 16'd2) begin errors++; $display("FAIL ur_count2 got %0d want 2", underrun_count); end
  endtask

  task automatic test_full();
    logic [31:0] e;
    logic signed [15:0] rx;
    logic signed [15:0] ry;
    prime_level = 6'd40;
    for (int i = 0; i < 32; i++) begin
      rx = 16'($urandom); ry = 16'($urandom);
      write_pair(rx, ry, 1'b1);
    end
    checks++; if (fill_level !== 6'd32) begin errors++; $display("FAIL full_fill got %0d want 32", fill_level); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL full_clamp_state got %0d want 1", state); end
    write_pair(16'sd7, 16'sd7, 1'b0);
    checks++; if (fill_level !== 6'd32) begin errors++; $display("FAIL full_reject got %0d want 32", fill_level); end
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL full_run got %0d want 2", state); end
    // Full plus strobe: no bypass, the write stays refused.
    wr_valid = 1'b1; wr_x = 16'sd9; wr_y = 16'sd9; ce_strobe = 1'b1;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_nobypass got %b want 0", wr_ready); end
    step(); wr_valid = 1'b0; ce_strobe = 1'b0;
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_x, out_y} !== e) begin errors++; $display("FAIL full_pop got v=%b %h want v=1 %h", out_valid, {out_x, out_y}, e); end
    checks++; if (fill_level !== 6'd31) begin errors++; $display("FAIL full_pop_fill got %0d want 31", fill_level); end
    // Simultaneous write and pop keep occupancy constant.
    wr_valid = 1'b1; wr_x = -16'sd1234; wr_y = 16'sd4321; ce_strobe = 1'b1;
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL conc_ready got %b want 1", wr_ready); end
    sb.push_back({wr_x, wr_y});
    step(); wr_valid = 1'b0; ce_strobe = 1'b0;
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || {out_x, out_y} !== e) begin errors++; $display("FAIL conc_pop got v=%b %h want v=1 %h", out_valid, {out_x, out_y}, e); end
    checks++; if (fill_level !== 6'd31) begin errors++; $display("FAIL conc_fill got %0d want 31", fill_level); end
  endtask

  task automatic test_disable();
    for (int i = 0; i < 21; i++) strobe_pop(6'(30 - i));
    enable = 1'b0; wr_valid = 1'b1; wr_x = 16'sd77; wr_y = 16'sd77;
    step(); wr_valid = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL dis_state got %0d want 0", state); end
    checks++; if (fill_level !== 6'd0) begin errors++; $display("FAIL dis_fill got %0d want 0", fill_level); end
    checks++; if (out_x !== 16'sd0 || out_y !== 16'sd0 || out_valid !== 1'b0) begin errors++; $display("FAIL dis_out got (%0d,%0d,%b) want (0,0,0)", out_x, out_y, out_valid); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL dis_ready got %b want 0", wr_ready); end
    checks++; if (underrun_count !== 16'd2) begin errors++; $display("FAIL dis_count got %0d want 2", underrun_count); end
    sb.delete();
    enable = 1'b1; step();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL reen_state got %0d want 1", state); end
  endtask

  task automatic test_rst_mid_run();
    prime_level = 6'd1;
    write_pair(16'sd11, -16'sd11, 1'b1);
    write_pair(16'sd22, -16'sd22, 1'b1);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL mr_run got %0d want 2", state); end
    rst = 1'b1; ce_strobe = 1'b1; wr_valid = 1'b1;
    step();
    rst = 1'b0; ce_strobe = 1'b0; wr_valid = 1'b0; enable = 1'b0;
    checks++; if (state !== 2'd0 || fill_level !== 6'd0) begin errors++; $display("FAIL mr_rst got state=%0d fill=%0d want 0 0", state, fill_level); end
    checks++; if (out_valid !== 1'b0 || out_x !== 16'sd0 || underrun_count !== 16'd0) begin errors++; $display("FAIL mr_out got v=%b x=%0d cnt=%0d want 0 0 0", out_valid, out_x, underrun_count); end
    sb.delete();
    step();
  endtask

  task automatic test_prime_zero();
    enable = 1'b1; prime_level = 6'd0;
    step();
    write_pair(16'sd55, -16'sd55, 1'b1);
    checks++; if (state !== 2'd1 || fill_level !== 6'd1) begin errors++; $display("FAIL pz_prime got state=%0d fill=%0d want 1 1", state, fill_level); end
    step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pz_run got %0d want 2", state); end
    strobe_pop(6'd0);
  endtask

  task automatic test_counter();
    for (int i = 0; i < 65537; i++) begin
      ce_strobe = 1'b1; wr_valid = 1'b1; wr_x = 16'(i); wr_y = 16'(i);
      step();
      ce_strobe = 1'b0; wr_valid = 1'b0;
      step();
      ce_strobe = 1'b1;
      step();
      ce_strobe = 1'b0;
      if (i == 65534) begin
        checks++; if (underrun_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_reach got %h want ffff", underrun_count); end
      end
    end
    checks++; if (underrun_count !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got %h want ffff", underrun_count); end
    checks++; if (state !== 2'd2 || fill_level !== 6'd0) begin errors++; $display("FAIL cnt_pos got state=%0d fill=%0d want 2 0", state, fill_level); end
    ce_strobe = 1'b1; underrun_clear = 1'b1;
    step();
    ce_strobe = 1'b0; underrun_clear = 1'b0;
    checks++; if (underrun_count !== 16'd0) begin errors++; $display("FAIL cnt_clear got %h want 0", underrun_count); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL cnt_clear_state got %0d want 1", state); end
  endtask

  initial begin
    test_reset();
    test_prime_run();
    test_underrun();
    test_full();
    test_disable();
    test_rst_mid_run();
    test_prime_zero();
    test_counter();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
